// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between program_counter and decode, with a generic FIFO helper.
// Latency: grant in cycle N plus rvalid in cycle N+k gives if_valid in cycle N+k+1.
// Backpressure: buffer-plus-in-flight credit gates imem_req/pc_en; decode stalls hold the head stable.
//
// Ports (fetch_stage):
//   clk, reset                 clock, asynchronous active-high reset
//   pc / pc_en                 current fetch address in, advance enable out
//   flush                      redirect; clears buffer, turns in-flight fetches into drops
//   imem_req/addr/gnt          request channel to instruction memory (addr == pc)
//   imem_rvalid/rdata          in-order response channel
//   if_valid/instr/pc, id_ready  valid/ready handoff to decode

// Generic synchronous FIFO with a clear. Storage is reset so the head reads zero out of reset.
// Latency: a push is visible at the head on the following cycle; the head is a direct storage read.
// Backpressure: none inside; callers never push when full or pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
    parameter int DEPTH     = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        id_ready
);
    // Counters hold 0..DEPTH; MAX_OUTST <= DEPTH so live and drop fit as well.
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] tag_count;
    logic [15:0]   tag_head;
    logic [47:0]   buf_head;

    logic accept;
    logic rsp_drop;
    logic rsp_live;
    logic rsp_any;
    logic pop;

    // One spare bit on the sums so the credit compares cannot wrap.
    assign imem_req = !reset && !flush
                    && (({1'b0, live} + {1'b0, drop}) < (CW+1)'(MAX_OUTST))
                    && (({1'b0, live} + {1'b0, buf_count}) < (CW+1)'(DEPTH));
    assign accept    = imem_req && imem_gnt;
    assign pc_en     = accept;
    assign imem_addr = pc;

    // Responses retire drops first: drops are always older than any live request.
    assign rsp_drop = imem_rvalid && (drop != '0);
    assign rsp_live = imem_rvalid && (drop == '0) && (live != '0);
    assign rsp_any  = rsp_drop || rsp_live;

    assign if_valid = (buf_count != '0) && !flush;
    assign pop      = if_valid && id_ready;
    assign if_pc    = buf_head[47:32];
    assign if_instr = buf_head[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live <= '0;
            drop <= '0;
        end else if (flush) begin
            // Everything still in flight becomes a drop; a response this cycle retires one of them.
            live <= '0;
            drop <= drop + live - CW'(rsp_any);
        end else begin
            live <= live + CW'(accept) - CW'(rsp_live);
            drop <= drop - CW'(rsp_drop);
        end
    end

    // Tag queue: pc of each live request, popped as its response lands in the buffer.
    fifo #(.W(16), .DEPTH(DEPTH)) u_tag (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .push     (accept),
        .push_dat (pc),
        .pop      (rsp_live),
        .head_dat (tag_head),
        .count    (tag_count)
    );

    fifo #(.W(48), .DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .push     (rsp_live),
        .push_dat ({tag_head, imem_rdata}),
        .pop      (pop),
        .head_dat (buf_head),
        .count    (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rvalid && (live == '0) && (drop == '0)))
                else $error("fetch_stage: imem_rvalid with no request in flight");
            assert (tag_count == live)
                else $error("fetch_stage: tag queue depth disagrees with live count");
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic        pc_en;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;

    fetch_stage #(.DEPTH(2), .MAX_OUTST(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] pend_q[$];
    bit          mem_hold = 1'b0;
    logic [15:0] flush_tgt = '0;
    logic [15:0] exp_pc = '0;
    int          n_del = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          first_acc = -1;
    int          first_vld = -1;

    logic        smp_req, smp_acc, smp_pcen, smp_vld, smp_del;
    logic [15:0] smp_addr, smp_pc;
    logic [31:0] smp_instr;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle; entered ~1 unit after a rising edge, returns ~1 unit after the next.
    // The memory answers each accepted request in order, one cycle later unless held.
    task automatic tick();
        if (!mem_hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        @(negedge clk);
        smp_req   = imem_req;
        smp_acc   = imem_req & imem_gnt;
        smp_pcen  = pc_en;
        smp_addr  = imem_addr;
        smp_vld   = if_valid;
        smp_pc    = if_pc;
        smp_instr = if_instr;
        smp_del   = if_valid & id_ready;
        chk("imem_addr", 48'(smp_addr), 48'(pc));
        if (smp_acc) acc_cnt++;
        if (smp_acc && first_acc < 0) first_acc = cyc;
        if (smp_vld && first_vld < 0) first_vld = cyc;
        if (smp_del) begin
            chk("deliv_pc", 48'(smp_pc), 48'(exp_pc));
            chk("deliv_instr", 48'(smp_instr), 48'(mem_word(exp_pc)));
            exp_pc = exp_pc + 16'd4;
            n_del++;
        end
        @(posedge clk);
        #1;
        if (imem_rvalid) pend_q.delete(0);
        if (smp_acc) pend_q.push_back(smp_addr);
        if (flush) pc = flush_tgt;
        else if (smp_pcen) pc = pc + 16'd4;
        flush = 1'b0;
        cyc++;
    endtask

    task automatic do_flush(input logic [15:0] tgt);
        flush     = 1'b1;
        flush_tgt = tgt;
        exp_pc    = tgt;
        tick();
        chk("flush_req", 48'(smp_req), 48'd0);
        chk("flush_vld", 48'(smp_vld), 48'd0);
    endtask

    initial begin
        int n0;
        logic [15:0] cap_pc;
        logic [31:0] cap_instr;
        bit have_cap;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", 48'(if_valid), 48'd0);
        chk("rst_if_instr", 48'(if_instr), 48'd0);
        chk("rst_if_pc", 48'(if_pc), 48'd0);
        chk("rst_imem_req", 48'(imem_req), 48'd0);
        chk("rst_pc_en", 48'(pc_en), 48'd0);

        // Short stream, then reset asserted in the middle of it.
        reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
        repeat (3) tick();
        #3;
        reset = 1'b1; imem_rvalid = 1'b0; pend_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; pc = 16'h0000; exp_pc = 16'h0000;
        cyc = 0; first_acc = -1; first_vld = -1; n_del = 0;

        // Streaming from 0x0000 with a one-cycle memory.
        repeat (8) tick();
        chk("lat_first_acc", 48'(first_acc), 48'd0);
        chk("lat_grant_to_valid", 48'(first_vld - first_acc), 48'd2);
        chk("stream_ndel_ge3", 48'(n_del >= 3), 48'd1);

        // Decode stall for 5 cycles.
        id_ready = 1'b0; acc_cnt = 0; have_cap = 1'b0;
        cap_pc = '0; cap_instr = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (smp_vld && !have_cap) begin
                cap_pc = smp_pc; cap_instr = smp_instr; have_cap = 1'b1;
            end
        end
        chk("stall_acc_le2", 48'(acc_cnt <= 2), 48'd1);
        chk("stall_req", 48'(smp_req), 48'd0);
        chk("stall_pc_en", 48'(smp_pcen), 48'd0);
        chk("stall_vld", 48'(smp_vld), 48'd1);
        chk("stall_head_pc", 48'(cap_pc), 48'(exp_pc));
        chk("stall_pc_stable", 48'(smp_pc), 48'(cap_pc));
        chk("stall_instr_stable", 48'(smp_instr), 48'(cap_instr));
        id_ready = 1'b1;
        n0 = n_del;
        repeat (6) tick();
        chk("resume_ndel_ge3", 48'(n_del - n0 >= 3), 48'd1);

        // Grant withheld for 3 cycles at pc 0x0010.
        imem_gnt = 1'b0;
        do_flush(16'h0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gnt0_pc_en", 48'(smp_pcen), 48'd0);
            chk("gnt0_pc_hold", 48'(smp_addr), 48'h0010);
        end
        chk("gnt0_req", 48'(smp_req), 48'd1);
        imem_gnt = 1'b1;
        n0 = n_del;
        repeat (6) tick();
        chk("gnt_resume_ndel", 48'(n_del - n0 >= 1), 48'd1);

        // Drain, build two live requests, flush with a response in the flush cycle.
        imem_gnt = 1'b0;
        repeat (4) tick();
        mem_hold = 1'b1; imem_gnt = 1'b1;
        repeat (3) tick();
        chk("hold_req_blocked", 48'(smp_req), 48'd0);
        chk("hold_pending2", 48'(pend_q.size()), 48'd2);
        mem_hold = 1'b0;
        do_flush(16'h0100);
        tick();
        chk("f1_req", 48'(smp_req), 48'd1);
        chk("f1_addr", 48'(smp_addr), 48'h0100);
        tick();
        chk("f2_vld", 48'(smp_vld), 48'd0);
        tick();
        chk("f3_vld", 48'(smp_vld), 48'd1);
        chk("f3_pc", 48'(smp_pc), 48'h0100);
        repeat (3) tick();

        // pc wrap.
        do_flush(16'hFFF8);
        n0 = n_del;
        repeat (10) tick();
        chk("wrap_ndel_ge3", 48'(n_del - n0 >= 3), 48'd1);

        // Async reset between edges with two requests outstanding.
        imem_gnt = 1'b0;
        repeat (4) tick();
        mem_hold = 1'b1; imem_gnt = 1'b1;
        repeat (2) tick();
        chk("pre_rst_pending2", 48'(pend_q.size()), 48'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_if_valid", 48'(if_valid), 48'd0);
        chk("arst_imem_req", 48'(imem_req), 48'd0);
        chk("arst_pc_en", 48'(pc_en), 48'd0);
        chk("arst_if_pc", 48'(if_pc), 48'd0);
        chk("arst_if_instr", 48'(if_instr), 48'd0);
        @(posedge clk); #1;
        pend_q.delete(); mem_hold = 1'b0; imem_gnt = 1'b0; pc = 16'h0000;
        reset = 1'b0;
        tick();
        chk("post_rst_req", 48'(smp_req), 48'd1);
        chk("post_rst_vld", 48'(smp_vld), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
